// File: rtl/t_func_grey_pkg.sv
// Shared helpers for the grey-coded FIFO pointer blocks.
// Holds the binary-to-grey conversion and the synchronizer depth floor.
// Pure declarations; no logic of its own.
package t_func_grey_pkg;

  // Fewest flops allowed on an asynchronous grey pointer crossing.
  localparam int MIN_SYNC_STAGES = 2;

  // Widest pointer the conversion helper handles. Callers zero-extend
  // narrower pointers; upper grey bits then stay zero.
  localparam int GREY_MAX_W = 32;

  // Binary to reflected grey code: each bit XORed with its upper neighbour.
  function automatic logic [GREY_MAX_W-1:0] bin2grey(input logic [GREY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/t_func_grey_sync.sv
// Multi-flop synchronizer for a grey-coded bus entering this clock domain.
// Latency: STAGES edges from d to q.
// No flow control; samples every edge and clears to 0 on synchronous reset.
module t_func_grey_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  // Shift the incoming bus down the flop chain; reset empties every stage.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/t_func_bin2grey_wptr.sv
// Write-side pointer of an async FIFO: binary counter, registered grey output, full flag.
// Latency: wptr_g and full update 1 edge after a push; full clears SYNC_STAGES+1 edges after rptr_g moves.
// Backpressure: wr_ack is withheld while full is set or reset_l is low.
module t_func_bin2grey_wptr
  import t_func_grey_pkg::*;
#(
  parameter int AW          = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          wr_req,
  output logic          wr_ack,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr_g,
  input  logic [AW:0]   rptr_g,
  output logic          full
);

  // Parameter sanity: the full compare needs two MSBs above the address
  // field, and a single flop is not a safe crossing.
  if (AW < 2) begin : g_chk_aw
    $fatal(1, "t_func_bin2grey_wptr: AW must be >= 2");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
    $fatal(1, "t_func_bin2grey_wptr: SYNC_STAGES below minimum");
  end
  if (AW + 1 > GREY_MAX_W) begin : g_chk_width
    $fatal(1, "t_func_bin2grey_wptr: pointer wider than grey helper");
  end

  logic [AW:0]            wbin;
  logic [AW:0]            wbin_next;
  logic [AW:0]            rq;
  logic [AW:0]            full_tgt;
  logic [GREY_MAX_W-1:0]  wgray_next;

  // Read pointer stays grey across the crossing; it is never decoded here.
  t_func_grey_sync #(
    .W      (AW + 1),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .d       (rptr_g),
    .q       (rq)
  );

  assign wr_ack    = wr_req & ~full & reset_l;
  assign waddr     = wbin[AW-1:0];
  assign wbin_next = wbin + {{AW{1'b0}}, wr_ack};

  // Conversion runs at the helper's full width; the zero-extended upper
  // grey bits must stay zero, so comparing at full width is still exact.
  assign wgray_next = bin2grey(GREY_MAX_W'(wbin_next));

  // In grey, "write is one lap ahead of read" means the two MSBs are
  // inverted and the remaining bits match.
  assign full_tgt = {~rq[AW:AW-1], rq[AW-2:0]};

  // Advance the binary pointer, publish its grey image and recompute full
  // from the post-push pointer so full shows on the very next cycle.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wbin   <= '0;
      wptr_g <= '0;
      full   <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wptr_g <= wgray_next[AW:0];
      full   <= (wgray_next == GREY_MAX_W'(full_tgt));
    end
  end

endmodule

// File: tb/tb_t_func_bin2grey_wptr.sv
// Directed bench for the write-side grey pointer generator.
// Two instances: AW=3/SYNC=2 for most vectors, AW=2/SYNC=3 for the deep-sync case.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_t_func_bin2grey_wptr;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       wr_req;
  logic       wr_ack;
  logic [2:0] waddr;
  logic [3:0] wptr_g;
  logic [3:0] rptr_g;
  logic       full;

  logic       wr_req2;
  logic       wr_ack2;
  logic [1:0] waddr2;
  logic [2:0] wptr_g2;
  logic [2:0] rptr_g2;
  logic       full2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  t_func_bin2grey_wptr #(.AW(3), .SYNC_STAGES(2)) u_dut (
    .clk     (clk),
    .reset_l (reset_l),
    .wr_req  (wr_req),
    .wr_ack  (wr_ack),
    .waddr   (waddr),
    .wptr_g  (wptr_g),
    .rptr_g  (rptr_g),
    .full    (full)
  );

  t_func_bin2grey_wptr #(.AW(2), .SYNC_STAGES(3)) u_dut2 (
    .clk     (clk),
    .reset_l (reset_l),
    .wr_req  (wr_req2),
    .wr_ack  (wr_ack2),
    .waddr   (waddr2),
    .wptr_g  (wptr_g2),
    .rptr_g  (rptr_g2),
    .full    (full2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grey sequence seen on wptr_g after each of the first 8 pushes from 0.
  logic [3:0] exp_seq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

  initial begin
    logic [3:0] prev;
    logic [3:0] d1, d2;
    bit         saw_wrap;

    reset_l = 1'b0;
    wr_req  = 1'b1;
    rptr_g  = 4'h0;
    wr_req2 = 1'b0;
    rptr_g2 = 3'h0;

    // 1. Reset held for two edges with a pending request.
    #1;
    chk("rst_ack0", wr_ack, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_wptr", wptr_g, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_full", full, 0);
      chk("rst_ack", wr_ack, 0);
    end

    // 2. Fill from empty with the read pointer parked at 0.
    reset_l = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("fill_ack", wr_ack, 1);
      chk("fill_waddr", waddr, i);
      tick();
      chk("fill_wptr", wptr_g, exp_seq[i]);
    end
    chk("fill_full", full, 1);
    chk("fill_noack", wr_ack, 0);
    tick();
    chk("full_hold_wptr", wptr_g, 4'hC);
    chk("full_hold_waddr", waddr, 0);
    chk("full_hold_full", full, 1);

    // 3. Read side frees one slot; full clears on the third edge.
    rptr_g = 4'h1;
    #1;
    chk("rel_noack", wr_ack, 0);
    tick();
    chk("rel_full_e1", full, 1);
    tick();
    chk("rel_full_e2", full, 1);
    chk("rel_wptr_hold", wptr_g, 4'hC);
    tick();
    chk("rel_full_e3", full, 0);
    chk("rel_ack", wr_ack, 1);
    tick();
    chk("rel_push_wptr", wptr_g, 4'hD);

    // 4. Long run with the read pointer trailing two cycles behind.
    reset_l = 1'b0;
    rptr_g  = 4'h0;
    tick();
    reset_l  = 1'b1;
    wr_req   = 1'b1;
    prev     = wptr_g;
    d1       = 4'h0;
    d2       = 4'h0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("run_1bit", 32'($countones(wptr_g ^ prev) <= 1), 1);
      chk("run_nofull", full, 0);
      if (prev == 4'h8 && wptr_g == 4'h0) saw_wrap = 1'b1;
      prev   = wptr_g;
      rptr_g = d2;
      d2     = d1;
      d1     = wptr_g;
    end
    chk("run_wrap_seen", saw_wrap, 1);

    // 5. Reset pulse in mid-stream wins over a held request.
    reset_l = 1'b0;
    rptr_g  = 4'h0;
    tick();
    reset_l = 1'b1;
    wr_req  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_wptr_pre", wptr_g, 4'h7);
    reset_l = 1'b0;
    #1;
    chk("mid_ack0", wr_ack, 0);
    tick();
    chk("mid_wptr", wptr_g, 0);
    chk("mid_waddr", waddr, 0);
    chk("mid_full", full, 0);
    reset_l = 1'b1;
    wr_req  = 1'b0;
    tick();
    chk("mid_idle_wptr", wptr_g, 0);

    // 6. Narrow pointer with a three-flop synchronizer.
    wr_req2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("n_ack", wr_ack2, 1);
      tick();
    end
    chk("n_wptr", wptr_g2, 3'b110);
    chk("n_full", full2, 1);
    chk("n_noack", wr_ack2, 0);
    rptr_g2 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n_full_hold", full2, 1);
    end
    tick();
    chk("n_full_clr", full2, 0);
    chk("n_ack_after", wr_ack2, 1);
    wr_req2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
